dc_vga_output_stage: RTL and testbench

Parametrised successor to the display controller's VGA output controller. It generates programmable horizontal and vertical video timing with configurable sync polarity and colour truncation. It pulls pixels from the IPU stream over a valid/ready handshake and reports blanking back to `dc_toplevel`. It also detects and counts pixel underruns, and can optionally generate a colour-bar test pattern. It sits between `dc_toplevel` (pixel source) and the board VGA pins.

---
 rtl/dc_vga_pkg.sv | 24 ++
 rtl/dc_vga_axis_counter.sv | 48 ++++
 rtl/dc_vga_output_stage.sv | 178 +++++++++++++++++
 tb/tb_dc_vga_output_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_vga_pkg.sv
// Shared types and constants for the VGA output stage: region encoding,
// pixel packing and the test-pattern bar colour mapping.
package dc_vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE      = 2'd0,
        FRONT_PORCH = 2'd1,
        SYNC        = 2'd2,
        BACK_PORCH  = 2'd3
    } region_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bar index bit that drives each channel full-on / full-off.
    localparam int BAR_R_BIT = 2;
    localparam int BAR_G_BIT = 1;
    localparam int BAR_B_BIT = 0;
    localparam int NUM_BARS  = 8;

endpackage

// File: rtl/dc_vga_axis_counter.sv
// One timing axis: wrapping counter over active/front porch/sync/back porch with region decode.
// Latency: count registered, region and wrap combinational from the current count.
// Backpressure: none; advances only on step, wrap flags the last step of a period.
module dc_vga_axis_counter
    import dc_vga_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FRONT_LEN  = 8,
    parameter int SYNC_LEN   = 96,
    parameter int BACK_LEN   = 40,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 step,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 wrap,
    output region_e              region
);

    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [CNT_WIDTH-1:0] LAST       = CNT_WIDTH'(TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] FP_START   = CNT_WIDTH'(ACTIVE_LEN);
    localparam logic [CNT_WIDTH-1:0] SYNC_START = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN);
    localparam logic [CNT_WIDTH-1:0] BP_START   = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

    assign wrap = step && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        region = ACTIVE;
        if (cnt >= BP_START) begin
            region = BACK_PORCH;
        end else if (cnt >= SYNC_START) begin
            region = SYNC;
        end else if (cnt >= FP_START) begin
            region = FRONT_PORCH;
        end
    end

endmodule

// File: rtl/dc_vga_output_stage.sv
// VGA timing + pixel output stage; DC_VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern.
// Latency: colours and syncs registered 1 cycle after counter state; ready/blank/frame_start combinational.
// Backpressure: pixel_ready high only in the active region; a missing pixel there is an underrun.
module dc_vga_output_stage
    import dc_vga_pkg::*;
#(
    parameter int H_ACTIVE             = 640,
    parameter int H_FRONT_PORCH        = 8,
    parameter int H_SYNC_PULSE         = 96,
    parameter int H_BACK_PORCH         = 40,
    parameter int V_ACTIVE             = 480,
    parameter int V_FRONT_PORCH        = 2,
    parameter int V_SYNC_PULSE         = 2,
    parameter int V_BACK_PORCH         = 25,
    parameter bit HS_ACTIVE_HIGH       = 1'b0,
    parameter bit VS_ACTIVE_HIGH       = 1'b0,
    parameter int BITS_PER_PIXEL       = 24,
    parameter int OUT_BITS_PER_CHANNEL = 4,
    parameter int CNT_WIDTH            = 12,
    parameter int UNDERRUN_CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            en,
    input  logic                            sw_test_en,
    input  logic                            pixel_valid,
    output logic                            pixel_ready,
    input  logic [BITS_PER_PIXEL-1:0]       pixel_data,
    output logic                            h_blank,
    output logic                            v_blank,
    output logic                            frame_start,
    output logic                            frame_underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0]   underrun_count,
    output logic                            o_hs,
    output logic                            o_vs,
    output logic [OUT_BITS_PER_CHANNEL-1:0] o_r,
    output logic [OUT_BITS_PER_CHANNEL-1:0] o_g,
    output logic [OUT_BITS_PER_CHANNEL-1:0] o_b
);

    localparam int CH_W  = BITS_PER_PIXEL / 3;
    localparam int OUT_W = OUT_BITS_PER_CHANNEL;

    logic [CNT_WIDTH-1:0] h_cnt;
    logic [CNT_WIDTH-1:0] v_cnt;
    region_e              h_region;
    region_e              v_region;
    logic                 h_wrap;
    logic                 v_wrap_unused;
    logic                 active_area;
    logic                 test_active;
    logic                 accept;
    logic                 underrun;
    logic [OUT_W-1:0]     pix_r, pix_g, pix_b;
    logic [OUT_W-1:0]     bar_r, bar_g, bar_b;
    logic                 unused_pixel_bits;

    dc_vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FRONT_PORCH),
        .SYNC_LEN   (H_SYNC_PULSE),
        .BACK_LEN   (H_BACK_PORCH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_h_axis (
        .clk    (clk),
        .nrst   (nrst),
        .step   (en),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .region (h_region)
    );

    dc_vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FRONT_PORCH),
        .SYNC_LEN   (V_SYNC_PULSE),
        .BACK_LEN   (V_BACK_PORCH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_v_axis (
        .clk    (clk),
        .nrst   (nrst),
        .step   (h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap_unused),
        .region (v_region)
    );

    assign h_blank     = (h_region != ACTIVE);
    assign v_blank     = (v_region != ACTIVE);
    assign active_area = !h_blank && !v_blank;
    assign pixel_ready = nrst && en && active_area && !test_active;
    assign accept      = pixel_valid && pixel_ready;
    assign underrun    = pixel_ready && !pixel_valid;
    assign frame_start = nrst && en && (h_cnt == '0) && (v_cnt == '0);

    // Only the top bits of each channel reach the pins.
    assign pix_r = pixel_data[BITS_PER_PIXEL-1 -: OUT_W];
    assign pix_g = pixel_data[2*CH_W-1 -: OUT_W];
    assign pix_b = pixel_data[CH_W-1 -: OUT_W];
    assign unused_pixel_bits = ^pixel_data;

`ifdef DC_VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    logic [CNT_WIDTH-1:0] bar_sub;
    logic [2:0]           bar_idx;

    assign test_active = sw_test_en;

    // Bar position tracks h_cnt / BAR_W by counting, restarting each blanking interval.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (en) begin
            if (h_blank) begin
                bar_sub <= '0;
                bar_idx <= '0;
            end else if (bar_sub == CNT_WIDTH'(BAR_W - 1)) begin
                bar_sub <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_sub <= bar_sub + 1'b1;
            end
        end
    end

    assign bar_r = {OUT_W{bar_idx[BAR_R_BIT]}};
    assign bar_g = {OUT_W{bar_idx[BAR_G_BIT]}};
    assign bar_b = {OUT_W{bar_idx[BAR_B_BIT]}};
`else
    logic unused_sw_test_en;

    assign test_active       = 1'b0;
    assign unused_sw_test_en = sw_test_en;
    assign bar_r             = '0;
    assign bar_g             = '0;
    assign bar_b             = '0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            o_r            <= '0;
            o_g            <= '0;
            o_b            <= '0;
            o_hs           <= !HS_ACTIVE_HIGH;
            o_vs           <= !VS_ACTIVE_HIGH;
            frame_underrun <= 1'b0;
            underrun_count <= '0;
        end else if (en) begin
            if (accept) begin
                o_r <= pix_r;
                o_g <= pix_g;
                o_b <= pix_b;
            end else if (test_active && active_area) begin
                o_r <= bar_r;
                o_g <= bar_g;
                o_b <= bar_b;
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
            o_hs <= (h_region == SYNC) ? HS_ACTIVE_HIGH : !HS_ACTIVE_HIGH;
            o_vs <= (v_region == SYNC) ? VS_ACTIVE_HIGH : !VS_ACTIVE_HIGH;
            // An underrun on the frame's first pixel keeps the flag for the new frame.
            if (underrun) begin
                frame_underrun <= 1'b1;
            end else if (frame_start) begin
                frame_underrun <= 1'b0;
            end
            if (underrun && (underrun_count != '1)) begin
                underrun_count <= underrun_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dc_vga_output_stage.sv
// Bench for dc_vga_output_stage: small-timing instance checked cycle by cycle against an
// arithmetic frame model, plus a wide-active instance for bars and a default instance for reset.
module tb_dc_vga_output_stage;
    import dc_vga_pkg::*;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance A: small timing, 4-bit underrun counter
    logic nrst_a, en_a, tst_a, vld_a, rdy_a, hb_a, vb_a, fs_a, fu_a, hs_a, vs_a;
    logic [23:0] dat_a;
    logic [3:0]  uc_a, r_a, g_a, b_a;
    // instance B: 16 active pixels for the bar pattern
    logic nrst_b, en_b, tst_b, vld_b, rdy_b, hb_b, vb_b, fs_b, fu_b, hs_b, vs_b;
    logic [23:0] dat_b;
    logic [15:0] uc_b;
    logic [3:0]  r_b, g_b, b_b;
    // instance C: default parameters
    logic nrst_c, en_c, tst_c, vld_c, rdy_c, hb_c, vb_c, fs_c, fu_c, hs_c, vs_c;
    logic [23:0] dat_c;
    logic [15:0] uc_c;
    logic [3:0]  r_c, g_c, b_c;

    dc_vga_output_stage #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
        .UNDERRUN_CNT_WIDTH(4)
    ) u_dut_a (
        .clk(clk), .nrst(nrst_a), .en(en_a), .sw_test_en(tst_a),
        .pixel_valid(vld_a), .pixel_ready(rdy_a), .pixel_data(dat_a),
        .h_blank(hb_a), .v_blank(vb_a), .frame_start(fs_a), .frame_underrun(fu_a),
        .underrun_count(uc_a), .o_hs(hs_a), .o_vs(vs_a), .o_r(r_a), .o_g(g_a), .o_b(b_a)
    );

    dc_vga_output_stage #(
        .H_ACTIVE(16), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB)
    ) u_dut_b (
        .clk(clk), .nrst(nrst_b), .en(en_b), .sw_test_en(tst_b),
        .pixel_valid(vld_b), .pixel_ready(rdy_b), .pixel_data(dat_b),
        .h_blank(hb_b), .v_blank(vb_b), .frame_start(fs_b), .frame_underrun(fu_b),
        .underrun_count(uc_b), .o_hs(hs_b), .o_vs(vs_b), .o_r(r_b), .o_g(g_b), .o_b(b_b)
    );

    dc_vga_output_stage u_dut_c (
        .clk(clk), .nrst(nrst_c), .en(en_c), .sw_test_en(tst_c),
        .pixel_valid(vld_c), .pixel_ready(rdy_c), .pixel_data(dat_c),
        .h_blank(hb_c), .v_blank(vb_c), .frame_start(fs_c), .frame_underrun(fu_c),
        .underrun_count(uc_c), .o_hs(hs_c), .o_vs(vs_c), .o_r(r_c), .o_g(g_c), .o_b(b_c)
    );

    // Frame model for instance A: beam position plus the values the pins should show.
    int          m_h, m_v;
    logic [11:0] m_rgb;
    logic        m_hs, m_vs, m_fu;
    logic [3:0]  m_uc;

    task automatic model_reset();
        m_h = 0; m_v = 0; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1; m_fu = 1'b0; m_uc = '0;
    endtask

    // One pixel clock on instance A: drive, check everything against the model, advance the model.
    task automatic step_a(input logic rst_n, input logic e, input logic v, input logic [23:0] d);
        logic exp_rdy, exp_fs, exp_hb, exp_vb, under;
        rgb_t px;
        nrst_a = rst_n; en_a = e; vld_a = v; dat_a = d;
        @(negedge clk);
        exp_hb  = (m_h >= HA);
        exp_vb  = (m_v >= VA);
        exp_rdy = rst_n && e && !exp_hb && !exp_vb;
        exp_fs  = rst_n && e && (m_h == 0) && (m_v == 0);
        n_cmp++;
        if ({rdy_a, hb_a, vb_a, fs_a} !== {exp_rdy, exp_hb, exp_vb, exp_fs}) begin
            n_err++;
            $display("FAIL comb h=%0d v=%0d rdy/hb/vb/fs got %b want %b", m_h, m_v,
                     {rdy_a, hb_a, vb_a, fs_a}, {exp_rdy, exp_hb, exp_vb, exp_fs});
        end
        n_cmp++;
        if ({r_a, g_a, b_a} !== m_rgb) begin
            n_err++; $display("FAIL colour h=%0d v=%0d got %h want %h", m_h, m_v, {r_a, g_a, b_a}, m_rgb);
        end
        n_cmp++;
        if ({hs_a, vs_a} !== {m_hs, m_vs}) begin
            n_err++; $display("FAIL sync h=%0d v=%0d got %b want %b", m_h, m_v, {hs_a, vs_a}, {m_hs, m_vs});
        end
        n_cmp++;
        if ({fu_a, uc_a} !== {m_fu, m_uc}) begin
            n_err++; $display("FAIL underrun got flag=%b cnt=%0d want flag=%b cnt=%0d", fu_a, uc_a, m_fu, m_uc);
        end
        if (!rst_n) begin
            model_reset();
        end else if (e) begin
            px    = d;
            under = exp_rdy && !v;
            m_rgb = (exp_rdy && v) ? {px.r[7:4], px.g[7:4], px.b[7:4]} : 12'h000;
            m_hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            m_vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            if (under) m_fu = 1'b1;
            else if (exp_fs) m_fu = 1'b0;
            if (under && m_uc != 4'hF) m_uc = m_uc + 4'd1;
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset_a();
        repeat (2) step_a(1'b0, 1'b1, 1'b1, 24'($urandom));
    endtask

    task automatic test_reset();
        nrst_a = 1'b0; en_a = 1'b1; vld_a = 1'b1; tst_a = 1'b0; dat_a = '0;
        @(posedge clk); #1;
        model_reset();
        repeat (3) step_a(1'b0, 1'b1, 1'b1, 24'($urandom));
        n_cmp++;
        if ({rdy_a, hs_a, vs_a, fu_a, uc_a, r_a} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0}) begin
            n_err++; $display("FAIL reset_state got rdy=%b hs=%b vs=%b fu=%b uc=%0d r=%h want 0 1 1 0 0 0",
                              rdy_a, hs_a, vs_a, fu_a, uc_a, r_a);
        end
    endtask

    task automatic test_first_pixel();
        int lows = 0, first = -1;
        apply_reset_a();
        for (int k = 0; k < HT; k++) begin
            step_a(1'b1, 1'b1, 1'b1, (k == 0) ? 24'hA5C3F0 : 24'($urandom));
            if (k == 0) begin
                n_cmp++;
                if ({r_a, g_a, b_a} !== 12'hACF) begin
                    n_err++; $display("FAIL first_pixel got %h want acf", {r_a, g_a, b_a});
                end
            end
            if (hs_a === 1'b0) begin
                lows++;
                if (first < 0) first = k;
            end
        end
        n_cmp++;
        if (lows != 3 || first != HA + HF) begin
            n_err++; $display("FAIL hsync_window got %0d clocks from h=%0d want 3 from h=%0d", lows, first, HA + HF);
        end
    endtask

    task automatic test_underrun();
        apply_reset_a();
        repeat (3) step_a(1'b1, 1'b1, 1'b0, 24'($urandom));
        n_cmp++;
        if ({r_a, g_a, b_a, uc_a, fu_a} !== {12'h000, 4'd3, 1'b1}) begin
            n_err++; $display("FAIL underrun3 got rgb=%h cnt=%0d flag=%b want 000 3 1", {r_a, g_a, b_a}, uc_a, fu_a);
        end
        repeat (HT * VT - 3) step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
        n_cmp++;
        if (fu_a !== 1'b1) begin
            n_err++; $display("FAIL underrun_sticky got %b want 1", fu_a);
        end
        step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
        n_cmp++;
        if ({fu_a, uc_a} !== {1'b0, 4'd3}) begin
            n_err++; $display("FAIL frame_clear got flag=%b cnt=%0d want 0 3", fu_a, uc_a);
        end
    endtask

    task automatic test_saturate();
        int seen = 0, guard = 0;
        apply_reset_a();
        while (seen < 40 && guard < 10 * HT * VT) begin
            if (m_h < HA && m_v < VA) seen++;
            step_a(1'b1, 1'b1, 1'b0, 24'($urandom));
            guard++;
            if (seen == 10 && m_h == 10 % HA) begin
                n_cmp++;
                if (uc_a !== 4'd10) begin
                    n_err++; $display("FAIL count_10 got %0d want 10", uc_a);
                end
            end
        end
        n_cmp++;
        if (seen != 40 || uc_a !== 4'hF) begin
            n_err++; $display("FAIL saturate got cnt=%0d after %0d underruns want 15 after 40", uc_a, seen);
        end
    endtask

    task automatic test_en_hold();
        logic [19:0] snap;
        int guard = 0;
        apply_reset_a();
        repeat (5) step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
        snap = {r_a, g_a, b_a, hs_a, vs_a, fu_a, uc_a[0]};
        repeat (10) step_a(1'b1, 1'b0, 1'b1, 24'($urandom));
        n_cmp++;
        if ({r_a, g_a, b_a, hs_a, vs_a, fu_a, uc_a[0]} !== snap) begin
            n_err++; $display("FAIL en_hold got %h want %h", {r_a, g_a, b_a, hs_a, vs_a, fu_a, uc_a[0]}, snap);
        end
        repeat (2) step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
        n_cmp++;
        if (hb_a !== 1'b0) begin
            n_err++; $display("FAIL en_resume_h7 h_blank got %b want 0", hb_a);
        end
        step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
        n_cmp++;
        if (hb_a !== 1'b1) begin
            n_err++; $display("FAIL en_resume_h8 h_blank got %b want 1", hb_a);
        end
        while (!(m_h == 0 && m_v == 0) && guard < 2 * HT * VT) begin
            step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * HT * VT) begin
            n_err++; $display("FAIL frame_wrap_timeout got %0d cycles want < %0d", guard, 2 * HT * VT);
        end
        repeat (3) step_a(1'b1, 1'b0, 1'b1, 24'($urandom));
        step_a(1'b1, 1'b1, 1'b1, 24'($urandom));
    endtask

    task automatic test_random();
        apply_reset_a();
        for (int i = 0; i < 1500; i++) begin
            step_a($urandom_range(0, 199) != 0, $urandom_range(0, 4) != 0,
                   $urandom_range(0, 3) != 0, 24'($urandom));
        end
    endtask

    task automatic test_pattern();
        logic [2:0]  bar;
        logic [11:0] exp;
        nrst_b = 1'b0; en_b = 1'b1; tst_b = 1'b1; vld_b = 1'b1; dat_b = 24'h123456;
        repeat (2) @(posedge clk);
        #1 nrst_b = 1'b1;
        for (int k = 0; k < 18; k++) begin
            dat_b = 24'($urandom);
            @(negedge clk);
            n_cmp++;
`ifdef DC_VGA_TEST_PATTERN_EN
            if (rdy_b !== 1'b0) begin
                n_err++; $display("FAIL pattern_ready k=%0d got %b want 0", k, rdy_b);
            end
            bar = 3'(k / 2);
            exp = (k < 16) ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
`else
            if (rdy_b !== (k < 16)) begin
                n_err++; $display("FAIL ignored_test_ready k=%0d got %b want %b", k, rdy_b, k < 16);
            end
            bar = '0;
            exp = (k < 16) ? {dat_b[23:20], dat_b[15:12], dat_b[7:4]} : 12'h000 | {9'h0, bar};
`endif
            @(posedge clk); #1;
            n_cmp++;
            if ({r_b, g_b, b_b} !== exp) begin
                n_err++; $display("FAIL pattern_colour h=%0d got %h want %h", k, {r_b, g_b, b_b}, exp);
            end
        end
        n_cmp++;
        if (uc_b !== 16'd0) begin
            n_err++; $display("FAIL pattern_underruns got %0d want 0", uc_b);
        end
    endtask

    task automatic test_reset_midline();
        nrst_c = 1'b0; en_c = 1'b1; tst_c = 1'b0; vld_c = 1'b1; dat_c = 24'hFFFFFF;
        @(posedge clk);
        #1 nrst_c = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        n_cmp++;
        if ({hs_c, hb_c} !== 2'b01) begin
            n_err++; $display("FAIL midline_sync got hs=%b hb=%b want 0 1", hs_c, hb_c);
        end
        nrst_c = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({hs_c, vs_c, hb_c, vb_c, rdy_c, fs_c, r_c, uc_c} !== {6'b110000, 4'h0, 16'h0}) begin
            n_err++; $display("FAIL midline_reset got hs=%b vs=%b hb=%b vb=%b rdy=%b fs=%b want 1 1 0 0 0 0",
                              hs_c, vs_c, hb_c, vb_c, rdy_c, fs_c);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (rdy_c !== 1'b0) begin
            n_err++; $display("FAIL reset_held_ready got %b want 0", rdy_c);
        end
        nrst_c = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy_c !== 1'b1) begin
            n_err++; $display("FAIL release_ready got %b want 1", rdy_c);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({r_c, g_c, b_c} !== 12'hFFF) begin
            n_err++; $display("FAIL pre_reset_pixel got %h want fff", {r_c, g_c, b_c});
        end
        nrst_c = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy_c !== 1'b0) begin
            n_err++; $display("FAIL reset_cycle_ready got %b want 0", rdy_c);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({r_c, g_c, b_c} !== 12'h000) begin
            n_err++; $display("FAIL reset_cycle_pixel got %h want 000", {r_c, g_c, b_c});
        end
        nrst_c = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst_a = 1'b0; en_a = 1'b1; tst_a = 1'b0; vld_a = 1'b0; dat_a = '0;
        nrst_b = 1'b0; en_b = 1'b1; tst_b = 1'b0; vld_b = 1'b0; dat_b = '0;
        nrst_c = 1'b0; en_c = 1'b1; tst_c = 1'b0; vld_c = 1'b0; dat_c = '0;
        test_reset();
        test_first_pixel();
        test_underrun();
        test_saturate();
        test_en_hold();
        test_random();
        test_pattern();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
